// File: rtl/breakout_pkg.sv
// Shared constants for the breakout brick/score logic.
// State codes, brick index width, NO_BRICK sentinel, default field size.
package breakout_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PLAY    = 2'd1;
  localparam logic [1:0] ST_CLEARED = 2'd2;
  localparam logic [1:0] ST_OVER    = 2'd3;

  localparam int BRICK_IDX_W    = 10;
  localparam int DEF_NUM_BRICKS = 12;

  localparam logic [BRICK_IDX_W-1:0] NO_BRICK = 10'd15;

endpackage

// File: rtl/score_accum.sv
// Saturating score accumulator, adds INC per add_en pulse.
// Ports: clk, reset (sync, high), clr, add_en -> sum[W-1:0].
module score_accum #(
  parameter int W   = 16,
  parameter int INC = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         add_en,
  output logic [W-1:0] sum
);

  localparam int WX = W + 1;
  localparam logic [W:0] INC_X = WX'(INC);
  localparam logic [W:0] MAX_X = {1'b0, {W{1'b1}}};

  logic [W:0] nxt;

  // one spare bit so the carry out is visible to the clamp
  assign nxt = {1'b0, sum} + INC_X;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= (nxt > MAX_X) ? {W{1'b1}} : nxt[W-1:0];
    end
  end

endmodule

// File: rtl/brick_manager.sv
// Breakout brick field, score, lives and play/clear/over sequencing.
// In: clk, reset, start, hit_valid, brick_num, ball_lost.
// Out: brick_status, score, lives, hit_ack, level_clear, game_over,
//      game_state. Define BRICK_HIT_LOCKOUT_EN for hit lockout.
module brick_manager
  import breakout_pkg::*;
#(
  parameter int NUM_BRICKS       = DEF_NUM_BRICKS,
  parameter int POINTS_PER_BRICK = 10,
  parameter int START_LIVES      = 3,
  parameter int SCORE_W          = 16,
  parameter int CLEAR_HOLD       = 60,
  parameter int HIT_LOCKOUT      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   hit_valid,
  input  logic [BRICK_IDX_W-1:0] brick_num,
  input  logic                   ball_lost,
  output logic [NUM_BRICKS-1:0]  brick_status,
  output logic [SCORE_W-1:0]     score,
  output logic [1:0]             lives,
  output logic                   hit_ack,
  output logic                   level_clear,
  output logic                   game_over,
  output logic [1:0]             game_state
);

  if (START_LIVES < 1 || START_LIVES > 3 ||
      CLEAR_HOLD < 1 || HIT_LOCKOUT < 0) begin : g_cfg_err
    $error("brick_manager: parameter out of range");
  end

  localparam int HOLD_W = $clog2(CLEAR_HOLD + 1);

  localparam logic [NUM_BRICKS-1:0] ALL_ONE = '1;
  localparam logic [BRICK_IDX_W-1:0] NB_IDX =
    BRICK_IDX_W'(NUM_BRICKS);
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(CLEAR_HOLD - 1);
  localparam logic [1:0] LIVES_LD = 2'(START_LIVES);

  logic [1:0]            state;
  logic [1:0]            state_n;
  logic [NUM_BRICKS-1:0] bricks_n;
  logic [NUM_BRICKS-1:0] hit_mask;
  logic [NUM_BRICKS-1:0] bricks_left;
  logic [HOLD_W-1:0]     hold_q;
  logic [HOLD_W-1:0]     hold_n;
  logic [1:0]            lives_n;
  logic                  hit_ok;
  logic                  accept;
  logic                  enter_play;

  assign game_state = state;

  // out-of-range indices shift the 1 off the top, leaving an empty mask
  assign hit_mask    = NUM_BRICKS'(1) << brick_num;
  assign bricks_left = brick_status & ~hit_mask;

  assign accept = (state == ST_PLAY) && hit_valid && hit_ok &&
                  (brick_num != NO_BRICK) &&
                  (brick_num < NB_IDX) &&
                  (|(brick_status & hit_mask));

  assign enter_play = start &&
                      ((state == ST_IDLE) || (state == ST_OVER));

`ifdef BRICK_HIT_LOCKOUT_EN
  localparam int LOCK_W = $clog2(HIT_LOCKOUT + 1);

  logic [LOCK_W-1:0] lock_q;

  always_ff @(posedge clk) begin
    if (reset || enter_play) begin
      lock_q <= '0;
    end else if (accept) begin
      lock_q <= LOCK_W'(HIT_LOCKOUT);
    end else if (lock_q != '0) begin
      lock_q <= lock_q - LOCK_W'(1);
    end
  end

  assign hit_ok = (lock_q == '0);
`else
  assign hit_ok = 1'b1;
`endif

  always_comb begin
    state_n  = state;
    bricks_n = brick_status;
    lives_n  = lives;
    hold_n   = hold_q;
    unique case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_n  = ST_PLAY;
          bricks_n = ALL_ONE;
          lives_n  = LIVES_LD;
        end
      end
      ST_PLAY: begin
        if (accept) begin
          bricks_n = bricks_left;
        end
        if (ball_lost && (lives != 2'd0)) begin
          lives_n = lives - 2'd1;
        end
        // losing the last life outranks clearing the last brick
        if (ball_lost && (lives == 2'd1)) begin
          state_n = ST_OVER;
        end else if (accept && (bricks_left == '0)) begin
          state_n = ST_CLEARED;
          hold_n  = HOLD_LD;
        end
      end
      ST_CLEARED: begin
        if (hold_q == '0) begin
          state_n  = ST_PLAY;
          bricks_n = ALL_ONE;
        end else begin
          hold_n = hold_q - HOLD_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      brick_status <= '0;
      lives        <= LIVES_LD;
      hold_q       <= '0;
      hit_ack      <= 1'b0;
      level_clear  <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_n;
      brick_status <= bricks_n;
      lives        <= lives_n;
      hold_q       <= hold_n;
      hit_ack      <= accept;
      level_clear  <= (state_n == ST_CLEARED);
      game_over    <= (state_n == ST_OVER);
    end
  end

  score_accum #(
    .W   (SCORE_W),
    .INC (POINTS_PER_BRICK)
  ) u_score (
    .clk    (clk),
    .reset  (reset),
    .clr    (enter_play),
    .add_en (accept),
    .sum    (score)
  );

endmodule

// File: tb/tb_brick_manager.sv
// Self-checking bench for brick_manager: directed scenarios plus
// randomized play compared against a behavioural game model.
module tb_brick_manager;

  localparam int NB   = 12;
  localparam int PTS  = 10;
  localparam int SW   = 8;
  localparam int HOLD = 60;
  localparam int LOCK = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          hit_valid = 1'b0;
  logic [9:0]    brick_num = 10'd15;
  logic          ball_lost = 1'b0;
  logic [NB-1:0] brick_status;
  logic [SW-1:0] score;
  logic [1:0]    lives;
  logic          hit_ack;
  logic          level_clear;
  logic          game_over;
  logic [1:0]    game_state;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model: state 0 idle, 1 play, 2 cleared, 3 over
  int         m_st    = 0;
  bit [NB-1:0] m_br   = '0;
  int         m_score = 0;
  int         m_lives = 3;
  bit         m_ack   = 0;
  int         m_hold  = 0;
  int         m_lock  = 0;

  always #5 clk = ~clk;

  brick_manager #(
    .NUM_BRICKS       (NB),
    .POINTS_PER_BRICK (PTS),
    .START_LIVES      (3),
    .SCORE_W          (SW),
    .CLEAR_HOLD       (HOLD),
    .HIT_LOCKOUT      (LOCK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .hit_valid    (hit_valid),
    .brick_num    (brick_num),
    .ball_lost    (ball_lost),
    .brick_status (brick_status),
    .score        (score),
    .lives        (lives),
    .hit_ack      (hit_ack),
    .level_clear  (level_clear),
    .game_over    (game_over),
    .game_state   (game_state)
  );

  function automatic void mdl_step(bit r, bit s, bit hv, int bn, bit bl);
    bit acc;
    if (r) begin
      m_st = 0; m_br = '0; m_score = 0; m_lives = 3;
      m_ack = 0; m_hold = 0; m_lock = 0;
      return;
    end
    m_ack = 0;
    acc = (m_st == 1) && hv && (bn < NB) && m_br[bn];
`ifdef BRICK_HIT_LOCKOUT_EN
    if (m_lock != 0) acc = 0;
`endif
    if (m_lock > 0) m_lock--;
    case (m_st)
      0, 3: begin
        if (s) begin
          m_st = 1; m_br = '1; m_score = 0; m_lives = 3; m_lock = 0;
        end
      end
      1: begin
        if (acc) begin
          m_br[bn] = 1'b0;
          m_score = (m_score + PTS > SMAX) ? SMAX : m_score + PTS;
          m_ack = 1;
          m_lock = LOCK;
        end
        if (bl) m_lives--;
        if (m_lives == 0) m_st = 3;
        else if (acc && m_br == 0) begin
          m_st = 2; m_hold = HOLD;
        end
      end
      2: begin
        m_hold--;
        if (m_hold == 0) begin
          m_st = 1; m_br = '1;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic tick(input bit r, input bit s, input bit hv,
                      input int bn, input bit bl);
    reset = r; start = s; hit_valid = hv;
    brick_num = bn[9:0]; ball_lost = bl;
    @(posedge clk);
    mdl_step(r, s, hv, bn, bl);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 15, 0);
  endtask

  task automatic test_reset;
    tick(1, 1, 1, 3, 1);
    tick(1, 1, 1, 3, 1);
    n_tests++;
    if ({game_state, brick_status, score, lives, hit_ack, level_clear,
         game_over} !== {2'd0, {NB{1'b0}}, {SW{1'b0}}, 2'd3, 3'b000}) begin
      n_fail++;
      $display("FAIL reset: st=%0d br=%h sc=%0d lv=%0d ack=%b lc=%b go=%b want 0 000 0 3 0 0 0",
               game_state, brick_status, score, lives, hit_ack,
               level_clear, game_over);
    end
    tick(0, 0, 1, 3, 1);
    n_tests++;
    if ({game_state, brick_status, lives, hit_ack} !==
        {2'd0, {NB{1'b0}}, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_ignore: st=%0d br=%h lv=%0d ack=%b want 0 000 3 0",
               game_state, brick_status, lives, hit_ack);
    end
  endtask

  task automatic test_start;
    tick(0, 1, 0, 15, 0);
    n_tests++;
    if ({game_state, brick_status, score, lives} !==
        {2'd1, 12'hFFF, SW'(0), 2'd3}) begin
      n_fail++;
      $display("FAIL start: st=%0d br=%h sc=%0d lv=%0d want 1 fff 0 3",
               game_state, brick_status, score, lives);
    end
  endtask

  task automatic test_hit;
    int bad [3] = '{15, 12, 1023};
    tick(0, 0, 1, 5, 0);
    n_tests++;
    if ({brick_status, score, hit_ack} !== {12'hFDF, SW'(10), 1'b1}) begin
      n_fail++;
      $display("FAIL hit5: br=%h sc=%0d ack=%b want fdf 10 1",
               brick_status, score, hit_ack);
    end
    tick(0, 0, 1, 5, 0);
    n_tests++;
    if ({brick_status, score, hit_ack} !== {12'hFDF, SW'(10), 1'b0}) begin
      n_fail++;
      $display("FAIL rehit5: br=%h sc=%0d ack=%b want fdf 10 0",
               brick_status, score, hit_ack);
    end
    foreach (bad[i]) begin
      tick(0, 0, 1, bad[i], 0);
      n_tests++;
      if ({brick_status, score, hit_ack} !== {12'hFDF, SW'(10), 1'b0}) begin
        n_fail++;
        $display("FAIL bad_idx%0d: br=%h sc=%0d ack=%b want fdf 10 0",
                 bad[i], brick_status, score, hit_ack);
      end
    end
  endtask

  task automatic test_level_clear;
    int n;
    for (int i = 0; i < NB; i++) begin
      if (i == 5) continue;
      idle(LOCK);
      tick(0, 0, 1, i, 0);
    end
    n_tests++;
    if ({game_state, brick_status, score, level_clear, hit_ack} !==
        {2'd2, 12'h000, SW'(120), 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL clear_entry: st=%0d br=%h sc=%0d lc=%b ack=%b want 2 000 120 1 1",
               game_state, brick_status, score, level_clear, hit_ack);
    end
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (!level_clear) break;
      n++;
      tick(0, (k == 20), (k % 2) == 1, k % NB, (k == 10));
    end
    n_tests++;
    if (n !== HOLD) begin
      n_fail++;
      $display("FAIL clear_hold: level_clear cycles=%0d want %0d", n, HOLD);
    end
    n_tests++;
    if ({game_state, brick_status, score, lives} !==
        {2'd1, 12'hFFF, SW'(120), 2'd3}) begin
      n_fail++;
      $display("FAIL refill: st=%0d br=%h sc=%0d lv=%0d want 1 fff 120 3",
               game_state, brick_status, score, lives);
    end
  endtask

  task automatic test_lives;
    for (int i = 1; i <= 3; i++) begin
      idle(2);
      tick(0, 0, 0, 15, 1);
      n_tests++;
      if ({lives, game_over, game_state} !==
          {2'(3 - i), (i == 3), (i == 3) ? 2'd3 : 2'd1}) begin
        n_fail++;
        $display("FAIL lost%0d: lv=%0d go=%b st=%0d want %0d %0d %0d",
                 i, lives, game_over, game_state, 3 - i, i == 3,
                 (i == 3) ? 3 : 1);
      end
    end
    tick(0, 0, 1, 0, 0);
    n_tests++;
    if ({game_state, brick_status, score, hit_ack} !==
        {2'd3, 12'hFFF, SW'(120), 1'b0}) begin
      n_fail++;
      $display("FAIL over_ignore: st=%0d br=%h sc=%0d ack=%b want 3 fff 120 0",
               game_state, brick_status, score, hit_ack);
    end
    tick(0, 1, 0, 15, 0);
    n_tests++;
    if ({game_state, brick_status, score, lives, game_over} !==
        {2'd1, 12'hFFF, SW'(0), 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL restart: st=%0d br=%h sc=%0d lv=%0d go=%b want 1 fff 0 3 0",
               game_state, brick_status, score, lives, game_over);
    end
  endtask

  task automatic test_simultaneous;
    idle(1); tick(0, 0, 0, 15, 1);
    idle(1); tick(0, 0, 0, 15, 1);
    for (int i = 0; i < NB - 1; i++) begin
      idle(LOCK);
      tick(0, 0, 1, i, 0);
    end
    idle(LOCK);
    tick(0, 0, 1, NB - 1, 1);
    n_tests++;
    if ({game_state, brick_status, hit_ack, level_clear, game_over,
         lives, score} !==
        {2'd3, 12'h000, 1'b1, 1'b0, 1'b1, 2'd0, SW'(120)}) begin
      n_fail++;
      $display("FAIL hit_and_lost: st=%0d br=%h ack=%b lc=%b go=%b lv=%0d sc=%0d want 3 000 1 0 1 0 120",
               game_state, brick_status, hit_ack, level_clear, game_over,
               lives, score);
    end
  endtask

  task automatic test_saturation;
    tick(1, 0, 0, 15, 0);
    tick(0, 1, 0, 15, 0);
    for (int lvl = 0; lvl < 2; lvl++) begin
      for (int i = 0; i < NB; i++) begin
        idle(LOCK);
        tick(0, 0, 1, i, 0);
      end
      for (int k = 0; k < 200; k++) begin
        if (!level_clear) break;
        idle(1);
      end
    end
    n_tests++;
    if ({game_state, score} !== {2'd1, SW'(240)}) begin
      n_fail++;
      $display("FAIL sat_base: st=%0d sc=%0d want 1 240", game_state, score);
    end
    idle(LOCK); tick(0, 0, 1, 0, 0);
    n_tests++;
    if (score !== SW'(250)) begin
      n_fail++;
      $display("FAIL sat_250: sc=%0d want 250", score);
    end
    idle(LOCK); tick(0, 0, 1, 1, 0);
    n_tests++;
    if (score !== SW'(SMAX)) begin
      n_fail++;
      $display("FAIL sat_clamp: sc=%0d want %0d", score, SMAX);
    end
    idle(LOCK); tick(0, 0, 1, 2, 0);
    n_tests++;
    if ({score, hit_ack, brick_status} !== {SW'(SMAX), 1'b1, 12'hFF8}) begin
      n_fail++;
      $display("FAIL sat_hold: sc=%0d ack=%b br=%h want %0d 1 ff8",
               score, hit_ack, brick_status, SMAX);
    end
  endtask

  task automatic test_reset_midgame;
    tick(1, 1, 1, 3, 1);
    n_tests++;
    if ({game_state, brick_status, score, lives, hit_ack, level_clear,
         game_over} !== {2'd0, {NB{1'b0}}, {SW{1'b0}}, 2'd3, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid: st=%0d br=%h sc=%0d lv=%0d ack=%b lc=%b go=%b want 0 000 0 3 0 0 0",
               game_state, brick_status, score, lives, hit_ack,
               level_clear, game_over);
    end
  endtask

`ifdef BRICK_HIT_LOCKOUT_EN
  task automatic test_lockout;
    tick(0, 1, 0, 15, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 1, 1);
    n_tests++;
    if ({brick_status, hit_ack, lives, score} !==
        {12'hFFE, 1'b0, 2'd2, SW'(10)}) begin
      n_fail++;
      $display("FAIL lockout: br=%h ack=%b lv=%0d sc=%0d want ffe 0 2 10",
               brick_status, hit_ack, lives, score);
    end
    idle(LOCK - 1);
    tick(0, 0, 1, 1, 0);
    n_tests++;
    if ({brick_status, hit_ack, score} !== {12'hFFC, 1'b1, SW'(20)}) begin
      n_fail++;
      $display("FAIL lock_expire: br=%h ack=%b sc=%0d want ffc 1 20",
               brick_status, hit_ack, score);
    end
  endtask
`endif

  task automatic test_random;
    logic [NB+SW+6:0] want;
    bit r, s, hv, bl;
    int bn;
    tick(1, 0, 0, 15, 0);
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 999) < 3);
      s  = ($urandom_range(0, 99) < 4);
      hv = $urandom_range(0, 1) == 1;
      bn = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 1023)
                                       : $urandom_range(0, NB - 1);
      bl = ($urandom_range(0, 99) < 1);
      tick(r, s, hv, bn, bl);
      want = {m_st[1:0], m_br, m_score[SW-1:0], m_lives[1:0], m_ack,
              (m_st == 2), (m_st == 3)};
      n_tests++;
      if ({game_state, brick_status, score, lives, hit_ack, level_clear,
           game_over} !== want) begin
        n_fail++;
        $display("FAIL random c=%0d: st=%0d br=%h sc=%0d lv=%0d ack=%b lc=%b go=%b want st=%0d br=%h sc=%0d lv=%0d ack=%b",
                 c, game_state, brick_status, score, lives, hit_ack,
                 level_clear, game_over, m_st, m_br, m_score, m_lives,
                 m_ack);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_hit();
    test_level_clear();
    test_lives();
    test_simultaneous();
    test_saturation();
    test_reset_midgame();
`ifdef BRICK_HIT_LOCKOUT_EN
    test_lockout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
